drive_74hc165: RTL and testbench

//  Reads a chain of 74HC165 parallel-in/serial-out shift registers (buttons/DIP switches) and returns the word in parallel.

---
 rtl/drive_74hc165.sv | 180 ++++++++++++++++++
 tb/tb_drive_74hc165.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/drive_74hc165.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : drive_74hc165
//  Description : Reads a chain of 74HC165 PISO shift registers. Each frame
//                pulses SH/LD_n to capture the pins, lets QH settle, clocks
//                the chain out MSB first and presents the word in parallel
//                together with a one-cycle valid strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module drive_74hc165 #(
  parameter int WIDTH   = 16,  // bits per frame, 8 per chained device
  parameter int CLK_DIV = 4    // sys_clk cycles per serial half-period
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             read_en,
  input  logic             data_ser,
  output logic             sh_ld_n,
  output logic             clk_inh,
  output logic             srclk,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_SHIFT  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Sequencer state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;      // cycle within current phase
  logic [BIT_W-1:0] bit_q, bit_d;      // bit index within SHIFT
  logic             half_q, half_d;    // 0 = srclk low half, 1 = high half
  logic [WIDTH-1:0] shreg_q, shreg_d;  // word being assembled

  // Registered outputs
  logic             sh_ld_n_q, sh_ld_n_d;
  logic             clk_inh_q, clk_inh_d;
  logic             srclk_q, srclk_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;

  logic             phase_end;

  assign phase_end = (cnt_q == CNT_LAST);

  // Next-state logic: phase sequencing, divider and serial capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    half_d  = half_q;
    shreg_d = shreg_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        half_d = 1'b0;
        if (read_en) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (phase_end) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SETTLE: begin
        if (phase_end) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          half_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SHIFT: begin
        if (phase_end) begin
          cnt_d = '0;
          if (!half_q) begin
            // QH is stable at the end of the low half: take it now.
            shreg_d = {shreg_q[WIDTH-2:0], data_ser};
            if (bit_q == BIT_LAST) begin
              // Last bit already on QH: no further srclk edge is needed.
              state_d = S_DONE;
            end else begin
              half_d = 1'b1;
            end
          end else begin
            half_d = 1'b0;
            bit_d  = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        half_d  = 1'b0;
      end
    endcase
  end

  // Output decode from the upcoming state so pins change with the phase
  always_comb begin
    sh_ld_n_d    = (state_d != S_LOAD);
    clk_inh_d    = !((state_d == S_SETTLE) || (state_d == S_SHIFT));
    srclk_d      = (state_d == S_SHIFT) && half_d;
    // Busy also covers the cycle in which the valid strobe is shown.
    busy_d       = (state_d != S_IDLE) || (state_q == S_DONE);
    data_valid_d = (state_q == S_DONE);
    data_out_d   = (state_q == S_DONE) ? shreg_q : data_out_q;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      half_q       <= 1'b0;
      shreg_q      <= '0;
      sh_ld_n_q    <= 1'b1;
      clk_inh_q    <= 1'b1;
      srclk_q      <= 1'b0;
      busy_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      half_q       <= half_d;
      shreg_q      <= shreg_d;
      sh_ld_n_q    <= sh_ld_n_d;
      clk_inh_q    <= clk_inh_d;
      srclk_q      <= srclk_d;
      busy_q       <= busy_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign sh_ld_n    = sh_ld_n_q;
  assign clk_inh    = clk_inh_q;
  assign srclk      = srclk_q;
  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_drive_74hc165.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_drive_74hc165
//  Description : Bench for drive_74hc165. Two instances (16-bit/div 4 and
//                8-bit/div 2), each reading a behavioural 74HC165 chain.
//                Expected words and valid cycles are queued at accept time
//                and compared when the strobe appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_drive_74hc165;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [1:0]  read_en_v;
  logic [31:0] pins_v;

  logic [1:0]  sh_v, inh_v, srclk_v, busy_v, valid_v;
  logic [31:0] dout_v;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int nvalid [2] = '{0, 0};

  always #5 sys_clk = ~sys_clk;

  // Edge counter: at a falling edge, cyc is the number of the last rising edge
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W   = (g == 0) ? 16 : 8;
    localparam int CD  = (g == 0) ? 4 : 2;
    localparam int LAT = (2 * W + 1) * CD + 1;

    logic         data_ser, sh_ld_n, clk_inh, srclk, busy, data_valid;
    logic [W-1:0] data_out;
    logic [W-1:0] chain;

    drive_74hc165 #(.WIDTH(W), .CLK_DIV(CD)) u_dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .read_en    (read_en_v[g]),
      .data_ser   (data_ser),
      .sh_ld_n    (sh_ld_n),
      .clk_inh    (clk_inh),
      .srclk      (srclk),
      .busy       (busy),
      .data_out   (data_out),
      .data_valid (data_valid)
    );

    // 74HC165 chain: parallel load while SH/LD_n low, shift on CLK rise
    always @(posedge srclk or negedge sh_ld_n) begin
      if (!sh_ld_n)      chain <= pins_v[g*16 +: W];
      else if (!clk_inh) chain <= {chain[W-2:0], 1'b0};
    end
    assign data_ser = chain[W-1];

    assign sh_v[g]            = sh_ld_n;
    assign inh_v[g]           = clk_inh;
    assign srclk_v[g]         = srclk;
    assign busy_v[g]          = busy;
    assign valid_v[g]         = data_valid;
    assign dout_v[g*16 +: 16] = 16'(data_out);

    exp_t q[$];
    logic mbusy   = 1'b0;
    logic srclk_p = 1'b0;
    int   e0      = 0;
    int   ld_cnt  = 0;
    int   rises   = 0;
    int   hi_len  = 0;

    // Scoreboard, pin-timing monitor and accept model for the next edge
    always @(negedge sys_clk) begin
      exp_t e;
      if (data_valid) begin
        nvalid[g]++;
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("valid_cycle", cyc, e.cyc);
          check("data_out", 32'(data_out), 32'(e.data));
          check("busy_at_valid", busy, 1);
          check("ld_low_cycles", ld_cnt, CD);
          check("srclk_rises", rises, W - 1);
        end
        ld_cnt = 0;
        rises  = 0;
      end else if (q.size() != 0 && cyc > q[0].cyc) begin
        check("valid_timeout", cyc, q[0].cyc);
        void'(q.pop_front());
      end

      if (!sh_ld_n) ld_cnt++;
      if (srclk && !srclk_p) begin
        rises++;
        hi_len = 0;
        check("inh_at_rise", clk_inh, 0);
      end
      if (srclk) hi_len++;
      if (!srclk && srclk_p) check("srclk_high_len", hi_len, CD);
      srclk_p = srclk;

      if (!rst_n) begin
        mbusy   = 1'b0;
        q.delete();
        ld_cnt  = 0;
        rises   = 0;
        hi_len  = 0;
        srclk_p = 1'b0;
      end else if (mbusy) begin
        if (cyc + 1 == e0 + LAT) mbusy = 1'b0;
      end else if (read_en_v[g]) begin
        mbusy  = 1'b1;
        e0     = cyc + 1;
        e.data = 16'(pins_v[g*16 +: W]);
        e.cyc  = e0 + LAT;
        q.push_back(e);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    read_en_v = 2'b00;
    pins_v    = 32'h0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_sh_ld_n", 32'(sh_v), 32'h3);
    check("rst_clk_inh", 32'(inh_v), 32'h3);
    check("rst_srclk", 32'(srclk_v), 32'h0);
    check("rst_busy", 32'(busy_v), 32'h0);
    check("rst_valid", 32'(valid_v), 32'h0);
    check("rst_data_out", dout_v, 32'h0);

    // T1: single frame
    pins_v[15:0] = 16'hA5C3;
    read_en_v[0] = 1'b1;
    tick(1);
    read_en_v[0] = 1'b0;
    tick(145);
    check("t1_hold", 32'(dout_v[15:0]), 32'hA5C3);
    check("t1_idle_busy", 32'(busy_v[0]), 32'h0);

    // T2: read_en held, pins change between frames
    pins_v[15:0] = 16'h0001;
    read_en_v[0] = 1'b1;
    tick(60);
    pins_v[15:0] = 16'h8000;
    tick(100);
    read_en_v[0] = 1'b0;
    tick(150);
    check("t2_frames", nvalid[0], 3);

    // T3: abort a frame with reset
    pins_v[15:0] = 16'h1234;
    read_en_v[0] = 1'b1;
    tick(1);
    read_en_v[0] = 1'b0;
    tick(145);
    check("t3_pre_data", 32'(dout_v[15:0]), 32'h1234);
    pins_v[15:0] = 16'hFFFF;
    read_en_v[0] = 1'b1;
    tick(1);
    read_en_v[0] = 1'b0;
    tick(50);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("t3_sh_ld_n", 32'(sh_v[0]), 32'h1);
    check("t3_srclk", 32'(srclk_v[0]), 32'h0);
    check("t3_busy", 32'(busy_v[0]), 32'h0);
    check("t3_data_out", 32'(dout_v[15:0]), 32'h0);
    check("t3_valid", 32'(valid_v[0]), 32'h0);
    tick(150);
    check("t3_no_valid", nvalid[0], 4);

    // T4: extra requests while busy, pins changed mid-SHIFT
    pins_v[15:0] = 16'h5A5A;
    read_en_v[0] = 1'b1;
    tick(1);
    read_en_v[0] = 1'b0;
    tick(10);
    read_en_v[0] = 1'b1;
    tick(1);
    read_en_v[0] = 1'b0;
    tick(30);
    read_en_v[0] = 1'b1;
    tick(1);
    read_en_v[0] = 1'b0;
    tick(27);
    pins_v[15:0] = 16'h00FF;
    tick(50);
    read_en_v[0] = 1'b1;
    tick(1);
    read_en_v[0] = 1'b0;
    tick(150);
    check("t4_single_valid", nvalid[0], 5);
    check("t4_data", 32'(dout_v[15:0]), 32'h5A5A);

    // T5: 8-bit chain, divide by 2
    pins_v[23:16] = 8'h3C;
    read_en_v[1]  = 1'b1;
    tick(1);
    read_en_v[1]  = 1'b0;
    tick(60);
    check("t5_data", 32'(dout_v[23:16]), 32'h3C);
    check("t5_valid_count", nvalid[1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
